// File: rtl/serial_pkg.sv
// Shared constants for the serial transmitter: state encodings, frame width
// and line levels.
package serial_pkg;

    localparam int DATA_BITS = 8;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;

    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/serial_transmitter_baud_tick_gen.sv
// Bit-period timer: counts 0..DIVISOR-1 and pulses tick on the last count.
// clear restarts the period at 0 so a frame's start bit gets a full DIVISOR cycles.
module baud_tick_gen #(
    parameter int DIVISOR = 5208
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int CW = (DIVISOR > 2) ? $clog2(DIVISOR) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIVISOR - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serial_transmitter.sv
// Serial transmitter: start bit, 8 data bits LSB-first, optional even parity
// (enabled by defining TX_PARITY_EN), stop bit. Each bit lasts DIVISOR clocks.
//
// state     | meaning
// ST_IDLE   | line high, ready to accept a word
// ST_START  | driving the start bit
// ST_DATA   | driving data bit bit_idx_q
// ST_PARITY | driving the parity bit (TX_PARITY_EN only)
// ST_STOP   | driving the stop bit
module serial_transmitter
    import serial_pkg::*;
#(
    parameter int DIVISOR = 5208
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_en,
    output logic       tx_status,
    output logic       dout
);

    localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

    logic [2:0] state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic       dout_q, dout_d;
    logic       accept;
    logic       tick;

    assign accept    = tx_en && (state_q == ST_IDLE);
    assign tx_status = (state_q == ST_IDLE);
    assign dout      = dout_q;

    baud_tick_gen #(
        .DIVISOR (DIVISOR)
    ) u_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (accept),
        .tick  (tick)
    );

`ifdef TX_PARITY_EN
    logic parity_q, parity_d;
`endif

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        dout_d    = dout_q;
`ifdef TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                dout_d = LINE_IDLE;
                if (tx_en) begin
                    state_d   = ST_START;
                    shift_d   = tx_data;
                    bit_idx_d = '0;
                    dout_d    = LINE_START;
`ifdef TX_PARITY_EN
                    parity_d  = even_parity(tx_data);
`endif
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d = ST_DATA;
                    dout_d  = shift_q[0];
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == LAST_IDX) begin
`ifdef TX_PARITY_EN
                        state_d = ST_PARITY;
                        dout_d  = parity_q;
`else
                        state_d = ST_STOP;
                        dout_d  = LINE_IDLE;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        dout_d    = shift_q[1];
                    end
                end
            end
`ifdef TX_PARITY_EN
            ST_PARITY: begin
                if (tick) begin
                    state_d = ST_STOP;
                    dout_d  = LINE_IDLE;
                end
            end
`endif
            ST_STOP: begin
                if (tick) begin
                    state_d = ST_IDLE;
                    dout_d  = LINE_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                dout_d  = LINE_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            dout_q    <= LINE_IDLE;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            dout_q    <= dout_d;
        end
    end

`ifdef TX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end
`endif

endmodule

// File: tb/tb_serial_transmitter.sv
// Bench for serial_transmitter (DIVISOR=4): frame-position model checked every
// cycle, a loopback receiver, and literal expectations per directed scenario.
module tb_serial_transmitter;

    localparam int D = 4;
`ifdef TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FL = NB * D;

    logic       clk;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_en;
    logic       tx_status;
    logic       dout;

    int nchk = 0;
    int nerr = 0;

    serial_transmitter #(.DIVISOR(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tx_data   (tx_data),
        .tx_en     (tx_en),
        .tx_status (tx_status),
        .dout      (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Frame as a list of line levels, one per bit period.
    function automatic logic [10:0] build_frame(input logic [7:0] d);
        logic [10:0] f;
        f = '1;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[1+i] = d[i];
`ifdef TX_PARITY_EN
        f[9] = ^d;
`endif
        return f;
    endfunction

    // Model: position within the current frame, counted from the accept edge.
    logic        m_busy;
    int          m_pos;
    logic [10:0] m_frame;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_pos  <= 0;
        end else if (m_busy) begin
            if (m_pos == FL - 1) m_busy <= 1'b0;
            else                 m_pos  <= m_pos + 1;
        end else if (tx_en) begin
            m_busy  <= 1'b1;
            m_pos   <= 0;
            m_frame <= build_frame(tx_data);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("model_dout", {31'b0, dout}, {31'b0, m_busy ? m_frame[m_pos / D] : 1'b1});
            check("model_status", {31'b0, tx_status}, {31'b0, !m_busy});
        end
    end

    // Loopback receiver sampling mid-bit.
    logic [7:0] rx_q[$];
    logic       par_q[$];
    int         ferr = 0;
    logic       r_busy = 1'b0;
    int         r_cnt;
    logic [7:0] r_byte;
    logic       r_par;

    always @(negedge clk) begin
        if (!rst_n) begin
            r_busy = 1'b0;
        end else if (!r_busy) begin
            if (dout == 1'b0) begin
                r_busy = 1'b1;
                r_cnt  = 0;
            end
        end else begin
            r_cnt++;
            if (r_cnt % D == D / 2) begin
                if (r_cnt / D >= 1 && r_cnt / D <= 8) r_byte[r_cnt / D - 1] = dout;
                if (NB == 11 && r_cnt / D == 9) r_par = dout;
                if (r_cnt / D == NB - 1) begin
                    if (dout !== 1'b1) ferr++;
                    rx_q.push_back(r_byte);
                    par_q.push_back(r_par);
                    r_busy = 1'b0;
                end
            end
        end
    end

    // Sends one word; optional stray request at frame cycle pulse_at. Returns
    // the number of busy cycles and the mid-bit line levels.
    task automatic send(input logic [7:0] d, input int pulse_at, input logic [7:0] pd,
                        output int low, output logic [10:0] bits);
        tx_data = d;
        tx_en   = 1'b1;
        low     = 0;
        bits    = '1;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (tx_status == 1'b0) begin
                low++;
                if (low % D == 2 && (low - 2) / D <= 10) bits[(low - 2) / D] = dout;
            end
            if (n == 0) begin
                tx_en   = 1'b0;
                tx_data = ~d;
            end
            if (pulse_at > 0 && low == pulse_at) begin
                tx_en   = 1'b1;
                tx_data = pd;
            end else if (pulse_at > 0 && low == pulse_at + 1) begin
                tx_en   = 1'b0;
            end
            if (tx_status == 1'b1 && low > 0) break;
        end
        tx_en = 1'b0;
    endtask

    task automatic wait_status(input logic v, input int bound, input string nm);
        for (int n = 0; n < bound; n++) begin
            @(negedge clk);
            if (tx_status == v) break;
        end
        check(nm, {31'b0, tx_status}, {31'b0, v});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", nerr + 1, nchk + 1);
        $fatal(1);
    end

    initial begin
        int          low;
        int          gap;
        int          nrx;
        logic [10:0] bits;
        logic        idle_ok;

        rst_n   = 1'b0;
        tx_en   = 1'b0;
        tx_data = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_dout", {31'b0, dout}, 32'd1);
        check("reset_status", {31'b0, tx_status}, 32'd1);
        rst_n = 1'b1;

        // 1: idle line
        idle_ok = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (dout !== 1'b1 || tx_status !== 1'b1) idle_ok = 1'b0;
        end
        check("idle_run", {31'b0, idle_ok}, 32'd1);

        // 2 + 3: 8'hA5 with a stray request at frame cycle 10
        send(8'hA5, 10, 8'hFF, low, bits);
        check("a5_busy_cycles", low, FL);
`ifdef TX_PARITY_EN
        check("a5_line_bits", {21'b0, bits}, 32'h54A);
`else
        check("a5_line_bits", {22'b0, bits[9:0]}, 32'h34A);
`endif
        repeat (20) @(negedge clk);
        check("a5_rx_count", rx_q.size(), 1);
        if (rx_q.size() >= 1) check("a5_rx_data", {24'b0, rx_q[0]}, 32'hA5);
        check("no_second_frame", {31'b0, tx_status}, 32'd1);

        // 4: back-to-back frames with tx_en held high
        nrx = rx_q.size();
        tx_data = 8'h00;
        tx_en   = 1'b1;
        wait_status(1'b0, 10, "b2b_first_accept");
        tx_data = 8'hFF;
        wait_status(1'b1, 100, "b2b_first_done");
        gap = 1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (tx_status == 1'b1) gap++;
            else break;
        end
        tx_en = 1'b0;
        check("b2b_gap", gap, 1);
        wait_status(1'b1, 100, "b2b_second_done");
        repeat (10) @(negedge clk);
        check("b2b_rx_count", rx_q.size(), nrx + 2);
        if (rx_q.size() >= nrx + 2) begin
            check("b2b_rx_first", {24'b0, rx_q[nrx]}, 32'h00);
            check("b2b_rx_second", {24'b0, rx_q[nrx+1]}, 32'hFF);
        end

        // 5: reset at frame cycle 17, then a fresh frame
        nrx = rx_q.size();
        tx_data = 8'h55;
        tx_en   = 1'b1;
        low     = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (tx_status == 1'b0) low++;
            if (n == 0) tx_en = 1'b0;
            if (low == 17) break;
        end
        check("abort_reached", low, 17);
        rst_n = 1'b0;
        #1;
        check("abort_dout", {31'b0, dout}, 32'd1);
        check("abort_status", {31'b0, tx_status}, 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_no_rx", rx_q.size(), nrx);
        send(8'h3C, 0, 8'h00, low, bits);
        check("3c_busy_cycles", low, FL);
        repeat (10) @(negedge clk);
        check("3c_rx_count", rx_q.size(), nrx + 1);
        if (rx_q.size() >= nrx + 1) check("3c_rx_data", {24'b0, rx_q[nrx]}, 32'h3C);

`ifdef TX_PARITY_EN
        // 6: parity bit values
        nrx = rx_q.size();
        send(8'h07, 0, 8'h00, low, bits);
        check("p07_busy_cycles", low, 44);
        send(8'h03, 0, 8'h00, low, bits);
        repeat (10) @(negedge clk);
        check("par_rx_count", rx_q.size(), nrx + 2);
        if (par_q.size() >= nrx + 2) begin
            check("p07_parity", {31'b0, par_q[nrx]}, 32'd1);
            check("p03_parity", {31'b0, par_q[nrx+1]}, 32'd0);
            check("p03_rx_data", {24'b0, rx_q[nrx+1]}, 32'h03);
        end
`endif

        check("stop_bits", ferr, 0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
